// File: rtl/dynamic_rca_pkg.sv
// Purpose: shared constants for the dynamic_rca adder slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dynamic_rca_pkg;

    // Legal operand-width range for the adder.
    localparam int DRCA_MAX_N = 32;
    localparam int DRCA_MIN_N = 1;

    // Returns 1 when a width lies inside the supported range.
    function automatic bit drca_width_ok(input int n);
        return (n >= DRCA_MIN_N) && (n <= DRCA_MAX_N);
    endfunction

endpackage : dynamic_rca_pkg

// File: rtl/fa.sv
// Purpose: 1-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, c (carry in) -> s (sum), co (carry out).
module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ c;
    assign co = (a & b) | (c & p);

endmodule : fa

// File: rtl/rca.sv
// Purpose: N-bit ripple-carry adder, a linear chain of full-adder cells.
// Latency: combinational, carry ripples from bit 0 to cout.
// Backpressure: none.
// Ports: a[N-1:0], b[N-1:0], cin -> s[N-1:0], cout.
module rca
    import dynamic_rca_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    // c[i] is the carry into cell i; c[N] leaves the MSB.
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .c  (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[N];

endmodule : rca

// File: rtl/register.sv
// Purpose: generic N-bit D flip-flop bank, loads every rising edge.
// Latency: 1 clock edge.
// Backpressure: none; there is no enable, the caller muxes feedback to hold.
// Ports: clk, rst_n (async active-low, clears to 0), in[N-1:0] -> out[N-1:0].
module register #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= in;
        end
    end

endmodule : register

// File: rtl/dynamic_rca.sv
// Purpose: N-bit ripple-carry adder with a registered operand stage and propagate output.
// Latency: 1 edge; S/Cout/P settle combinationally after the capturing edge.
// Backpressure: none; enable is a level sampled on the rising edge, low holds operands.
// Ports: clk, rst_n (async active-low), enable, A[N-1:0], B[N-1:0], Cin
//        -> S[N-1:0], Cout, P[N-1:0] (= A_q ^ B_q).
module dynamic_rca
    import dynamic_rca_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic [N-1:0] P
);

    // Operand stage packs {Cin_q, B_q, A_q}; 2N+1 bits never collapses to zero width.
    localparam int OPW = 2 * N + 1;

    logic [OPW-1:0] op_d;
    logic [OPW-1:0] op_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           cin_q;

    // The generic register has no enable, so hold is done by feeding its output back.
    assign op_d = enable ? {Cin, B, A} : op_q;

    register #(
        .N (OPW)
    ) u_op_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (op_d),
        .out   (op_q)
    );

    assign a_q   = op_q[N-1:0];
    assign b_q   = op_q[2*N-1:N];
    assign cin_q = op_q[2*N];

    rca #(
        .N (N)
    ) u_rca (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .s    (S),
        .cout (Cout)
    );

    assign P = a_q ^ b_q;

endmodule : dynamic_rca

// File: tb/tb_dynamic_rca.sv
module tb_dynamic_rca;

    logic clk;
    logic rst_n;
    logic enable;

    // N=8 instance
    logic [7:0]  a8, b8, s8, p8;
    logic        cin8, cout8;
    logic [8:0]  samp8;
    // N=32 instance
    logic [31:0] a32, b32, s32, p32;
    logic        cin32, cout32;
    logic [32:0] samp32;
    // N=1 instance
    logic [0:0]  a1, b1, s1, p1;
    logic        cin1, cout1;

    int checks;
    int failures;

    dynamic_rca #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .A(a8), .B(b8), .Cin(cin8), .S(s8), .Cout(cout8), .P(p8)
    );
    dynamic_rca #(.N(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .A(a32), .B(b32), .Cin(cin32), .S(s32), .Cout(cout32), .P(p32)
    );
    dynamic_rca #(.N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .A(a1), .B(b1), .Cin(cin1), .S(s1), .Cout(cout1), .P(p1)
    );

    // Downstream samplers of {Cout, S}.
    register #(.N(9))  u_samp8  (.clk(clk), .rst_n(rst_n), .in({cout8, s8}),   .out(samp8));
    register #(.N(33)) u_samp32 (.clk(clk), .rst_n(rst_n), .in({cout32, s32}), .out(samp32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_s;
        logic       exp_cout;
        logic [7:0] exp_p;
    } vec8_t;

    vec8_t tbl[8];

    // Reference: operands held by the design, tracked at transaction level.
    longint unsigned ref8_sum, ref8_prev, ref32_sum, ref32_prev;
    logic [7:0]  h8a, h8b;
    logic        h8c;
    logic [31:0] h32a, h32b;
    logic        h32c;

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFE};
        tbl[1] = '{8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 8'h30};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00};
        tbl[4] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 8'hFF};
        tbl[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 8'hFF};
        tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8'h7E};

        // Reset with enable high and non-zero inputs: reset must win.
        rst_n  = 1'b0;
        enable = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'h1; cin32 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick(); tick();
        check("reset_s8",    {56'd0, s8},   64'd0);
        check("reset_cout8", {63'd0, cout8}, 64'd0);
        check("reset_p8",    {56'd0, p8},   64'd0);
        check("reset_s32",   {32'd0, s32},  64'd0);
        check("reset_p32",   {32'd0, p32},  64'd0);
        check("reset_samp8", {55'd0, samp8}, 64'd0);
        check("reset_s1",    {62'd0, cout1, s1}, 64'd0);
        rst_n = 1'b1;

        // Table vectors, N=8, plus downstream sample one edge later.
        for (int i = 0; i < 8; i++) begin
            a8 = tbl[i].a; b8 = tbl[i].b; cin8 = tbl[i].cin;
            tick();
            check($sformatf("tbl%0d_s", i),    {56'd0, s8},   {56'd0, tbl[i].exp_s});
            check($sformatf("tbl%0d_cout", i), {63'd0, cout8}, {63'd0, tbl[i].exp_cout});
            check($sformatf("tbl%0d_p", i),    {56'd0, p8},   {56'd0, tbl[i].exp_p});
            tick();
            check($sformatf("tbl%0d_samp", i), {55'd0, samp8}, {55'd0, tbl[i].exp_cout, tbl[i].exp_s});
        end

        // N=32 full ripple and mixed pattern.
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1;
        tick();
        check("n32_ripple_s",    {32'd0, s32},   64'd0);
        check("n32_ripple_cout", {63'd0, cout32}, 64'd1);
        check("n32_ripple_p",    {32'd0, p32},   64'hFFFF_FFFF);
        a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; cin32 = 1'b0;
        tick();
        check("n32_mix_s",    {32'd0, s32},   64'hACF1_3568);
        check("n32_mix_cout", {63'd0, cout32}, 64'd0);
        check("n32_mix_p",    {32'd0, p32},   64'h8888_8888);
        tick();
        check("n32_mix_samp", {31'd0, samp32}, 64'h0_ACF1_3568);

        // N=1 exhaustive sweep.
        for (int v = 0; v < 8; v++) begin
            a1 = v[0]; b1 = v[1]; cin1 = v[2];
            tick();
            check($sformatf("n1_sum_%0d", v), {62'd0, cout1, s1}, 64'(v[0] + v[1] + v[2]));
            check($sformatf("n1_p_%0d", v),   {63'd0, p1},        {63'd0, v[0] ^ v[1]});
        end

        // Hold: enable low keeps the captured operands over 3 edges.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1;
        tick();
        check("hold_cap_s", {56'd0, s8}, 64'h31);
        enable = 1'b0;
        a8 = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold_s_%0d", k), {56'd0, s8}, 64'h31);
            check($sformatf("hold_p_%0d", k), {56'd0, p8}, 64'h30);
        end

        // Reset between edges clears everything immediately.
        enable = 1'b1;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        tick();
        check("mid_cap_cout", {63'd0, cout8}, 64'd1);
        tick();
        check("mid_cap_samp", {55'd0, samp8}, 64'h100);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_s",    {56'd0, s8},   64'd0);
        check("mid_rst_cout", {63'd0, cout8}, 64'd0);
        check("mid_rst_p",    {56'd0, p8},   64'd0);
        check("mid_rst_samp", {55'd0, samp8}, 64'd0);
        tick();
        rst_n = 1'b1;
        a8 = 8'h21; b8 = 8'h43; cin8 = 1'b0;
        tick();
        check("post_rst_s", {56'd0, s8}, 64'h64);

        // Randomized run against a transaction-level model, with random enable.
        h8a = a8; h8b = b8; h8c = cin8;
        h32a = a32; h32b = b32; h32c = cin32;
        ref8_prev  = 64'(h8a) + 64'(h8b) + 64'(h8c);
        ref32_prev = 64'(h32a) + 64'(h32b) + 64'(h32c);
        for (int n = 0; n < 400; n++) begin
            enable = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            if (enable) begin
                h8a = a8; h8b = b8; h8c = cin8;
                h32a = a32; h32b = b32; h32c = cin32;
            end
            ref8_sum  = 64'(h8a) + 64'(h8b) + 64'(h8c);
            ref32_sum = 64'(h32a) + 64'(h32b) + 64'(h32c);
            tick();
            check("rnd8_sum",   {55'd0, cout8, s8},   ref8_sum);
            check("rnd8_p",     {56'd0, p8},          {56'd0, h8a ^ h8b});
            check("rnd8_samp",  {55'd0, samp8},       ref8_prev);
            check("rnd32_sum",  {31'd0, cout32, s32}, ref32_sum);
            check("rnd32_samp", {31'd0, samp32},      ref32_prev);
            ref8_prev  = ref8_sum;
            ref32_prev = ref32_sum;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dynamic_rca
